// File: rtl/seq_cla_adder_pkg.sv
// ============================================================================
// seq_cla_adder_pkg: shared state encoding, slice width and index-width helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package seq_cla_adder_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // clog2 of the slice count, never below one bit so a single-slice adder still has an index
  function automatic int idx_width(input int nslice);
    int w;
    w = 1;
    while ((1 << w) < nslice) w++;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_cla_adder_cla4_slice.sv
// ============================================================================
// cla4_slice: combinational 4-bit carry-lookahead adder slice
// Revision: 1.0
// ============================================================================
`default_nettype none

module cla4_slice
  import seq_cla_adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               c3,
  output logic               c4
);

  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] g;
  logic               c1;
  logic               c2;

  assign p = a ^ b;
  assign g = a & b;

  // Every carry is a flat sum of products of g/p/cin, no ripple chain
  assign c1 = g[0] | (p[0] & cin);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum = p ^ {c3, c2, c1, cin};

endmodule

`default_nettype wire

// File: rtl/seq_cla_adder.sv
// ============================================================================
// seq_cla_adder: WIDTH-bit adder, one 4-bit lookahead slice per clock, LSB first
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_cla_adder
  import seq_cla_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = idx_width(NSLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_t             state;
  logic [WIDTH-1:0]   x_r;
  logic [WIDTH-1:0]   y_r;
  logic               carry_r;
  logic [IDX_W-1:0]   idx;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_c3;
  logic               slice_c4;

  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx == IDX_W'(i)) begin
        slice_a = x_r[i*SLICE_W +: SLICE_W];
        slice_b = y_r[i*SLICE_W +: SLICE_W];
      end
    end
  end

  cla4_slice u_slice (
    .a   (slice_a),
    .b   (slice_b),
    .cin (carry_r),
    .sum (slice_sum),
    .c3  (slice_c3),
    .c4  (slice_c4)
  );

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x_r       <= '0;
      y_r       <= '0;
      carry_r   <= 1'b0;
      idx       <= '0;
      out_valid <= 1'b0;
      Sum       <= '0;
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_r     <= X;
            y_r     <= Y;
            carry_r <= Cin;
            idx     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NSLICE; i++) begin
            if (idx == IDX_W'(i)) Sum[i*SLICE_W +: SLICE_W] <= slice_sum;
          end
          carry_r <= slice_c4;
          idx     <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            Cout      <= slice_c4;
            Ovf       <= slice_c3 ^ slice_c4;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // Results are held after the handshake until the next capture overwrites them
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_cla_adder.sv
// ============================================================================
// tb_seq_cla_adder: directed vector table plus backpressure and mid-run reset
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seq_cla_adder;

  localparam int WIDTH   = 16;
  localparam int LATENCY = 5;   // edges from accept edge (inclusive) until out_valid is seen

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;

  int n_cmp = 0;
  int n_bad = 0;

  seq_cla_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .Cin       (Cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .Ovf       (Ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offer one job at the next edge and wait (bounded) for out_valid; returns edges taken
  task automatic start_and_wait(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                input logic cin, output int lat);
    @(negedge clk);
    X = x; Y = y; Cin = cin; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0};
    vecs[7] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0};

    // Reset with arbitrary inputs applied
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    X         = 16'($urandom);
    Y         = 16'($urandom);
    Cin       = 1'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset Sum", 32'(Sum), 32'd0);
    chk("reset Cout", 32'(Cout), 32'd0);
    chk("reset Ovf", 32'(Ovf), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b1;

    for (int i = 0; i < 8; i++) begin
      start_and_wait(vecs[i].x, vecs[i].y, vecs[i].cin, lat);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(LATENCY));
      chk($sformatf("vec%0d Sum", i), 32'(Sum), 32'(vecs[i].sum));
      chk($sformatf("vec%0d Cout", i), 32'(Cout), 32'(vecs[i].cout));
      chk($sformatf("vec%0d Ovf", i), 32'(Ovf), 32'(vecs[i].ovf));
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d out_valid drop", i), 32'(out_valid), 32'd0);
      chk($sformatf("vec%0d in_ready back", i), 32'(in_ready), 32'd1);
    end

    // Backpressure: result held, new offers ignored
    out_ready = 1'b0;
    start_and_wait(16'h1234, 16'h4321, 1'b0, lat);
    chk("bp latency", 32'(lat), 32'(LATENCY));
    for (int k = 0; k < 10; k++) begin
      X = 16'($urandom); Y = 16'($urandom); Cin = 1'($urandom);
      in_valid = k[0];
      @(posedge clk);
      @(negedge clk);
      chk("bp out_valid", 32'(out_valid), 32'd1);
      chk("bp Sum", 32'(Sum), 32'h5555);
      chk("bp in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp release out_valid", 32'(out_valid), 32'd0);
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    chk("bp Sum readable", 32'(Sum), 32'h5555);

    // Reset while RUN is at slice index 2
    X = 16'hFFFF; Y = 16'h0001; Cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun rst in_ready", 32'(in_ready), 32'd1);
    chk("midrun rst out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (8) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("midrun never valid", 32'(seen), 32'd0);
    end
    start_and_wait(16'h00FF, 16'h0001, 1'b0, lat);
    chk("post-reset latency", 32'(lat), 32'(LATENCY));
    chk("post-reset Sum", 32'(Sum), 32'h0100);
    chk("post-reset Cout", 32'(Cout), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
